// File: rtl/regfile_mp.sv
// Multi-ported integer register file with x0 hardwired to zero, optional
// same-cycle write forwarding and a per-register pending-write scoreboard.
module regfile_mp #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  output logic [NREGS-1:0]      busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;

  // Later write ports override earlier ones; an issue set lands after any clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NREGS); r++) regs[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int w = 0; w < int'(NWR); w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
          regs[wr_addr[w*AW +: AW]]   <= wr_data[w*XLEN +: XLEN];
          busy_q[wr_addr[w*AW +: AW]] <= 1'b0;
        end
      end
      if (iss_valid && (iss_rd != '0)) busy_q[iss_rd] <= 1'b1;
    end
  end

  assign busy_vec = busy_q;

  for (genvar p = 0; p < int'(NRD); p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data_c;
    logic            busy_c;

    assign ra = rd_addr[p*AW +: AW];

    // Forwarded data supersedes the stored copy and the busy flag.
    always_comb begin
      data_c = (ra == '0) ? '0 : regs[ra];
      busy_c = busy_q[ra];
      if (BYPASS != 0) begin
        for (int w = 0; w < int'(NWR); w++) begin
          if (wr_en[w] && (wr_addr[w*AW +: AW] == ra) && (ra != '0)) begin
            data_c = wr_data[w*XLEN +: XLEN];
            busy_c = 1'b0;
          end
        end
      end
    end

    assign rd_data[p*XLEN +: XLEN] = data_c;
    assign rd_busy[p]              = busy_c;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 64: register width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of two, >= 2; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2: number of read ports.
REQ-004 SHALL have parameter NWR, default 2: number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = none.
REQ-006 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port rd_addr, input, NRD*AW: packed read addresses; port p is bits [p*AW +: AW].
REQ-009 SHALL have port rd_data, output, NRD*XLEN: packed read data, with the same packing.
REQ-010 SHALL have port rd_busy, output, NRD: pending-write flag for each read port's register.
REQ-011 SHALL have port wr_en, input, NWR: write enable per write port.
REQ-012 SHALL have port wr_addr, input, NWR*AW: packed write addresses.
REQ-013 SHALL have port wr_data, input, NWR*XLEN: packed write data.
REQ-014 SHALL have port iss_valid, input, 1: issue of an instruction that will later write iss_rd.
REQ-015 SHALL have port iss_rd, input, AW: destination register of the issue.
REQ-016 SHALL have port busy_vec, output, NREGS: full scoreboard, bit r = register r pending.

Function
REQ-017 SHALL hold register 0 at constant zero: writes to address 0 are discarded, rd_data reads 0 and busy bit 0 never sets.
REQ-018 SHALL, for each wr_en[w] with wr_addr != 0, update the register with wr_data[w] at the next rising edge.
REQ-019 SHALL resolve multiple enabled write ports targeting the same address in one cycle by letting the highest port index win.
REQ-020 SHALL make rd_data combinational from rd_addr and stored state; with BYPASS=0, a write becomes visible the cycle after wr_en.
REQ-021 SHALL, with BYPASS=1, forward wr_data of the winning enabled write port (per REQ-019) to any read port whose rd_addr matches a nonzero wr_addr in the same cycle.
REQ-022 SHALL keep a per-register busy bit: iss_valid with iss_rd != 0 sets bit iss_rd at the next edge; an enabled write to r clears bit r at the next edge.
REQ-023 SHALL give set priority when a set and a clear hit the same register in one cycle; the bit is 1 after the edge.
REQ-024 SHALL clear a busy bit on a write to a non-busy register; this is legal and a no-op on the scoreboard.
REQ-025 SHALL drive busy_vec from the registered scoreboard.
REQ-026 SHALL drive rd_busy[p] as busy_vec[rd_addr[p]]; with BYPASS=1 it is additionally masked to 0 when a same-cycle write matches (the data is forwarded).
REQ-027 SHALL accept any read address without range checks; all AW-bit values are valid indices.

Reset
REQ-028 SHALL, on rst high at a rising edge, clear all registers and all busy bits to 0, overriding writes and issues in that cycle.
REQ-029 SHALL make rd_data and rd_busy read 0 for all ports the cycle after reset, with BYPASS=1 forwarding still applying to same-cycle writes.
REQ-030 SHALL bring all registers and busy bits to 0 on an rst applied mid-operation, discarding pending scoreboard state.

Verification
REQ-031 SHALL cover: write x5=0xDEAD_BEEF on port 0, read x5 on both ports next cycle -> both rd_data = 0xDEAD_BEEF.
REQ-032 SHALL cover: wr_en=2'b11, both ports addr x7, data 0x11/0x22 -> x7 = 0x22 after the edge.
REQ-033 SHALL cover: write x0=0xFFFF, iss_rd=0 -> rd_data(x0) = 0 and busy_vec[0] = 0.
REQ-034 SHALL cover: BYPASS=1, write x3=0x55 while reading x3 in the same cycle -> rd_data = 0x55, rd_busy = 0; BYPASS=0 -> old value, 0x55 next cycle.
REQ-035 SHALL cover: issue x9, then write x9 together with a new issue of x9 in the same cycle -> busy_vec[9] = 1 after that edge, and 0 after a later write with no issue.
REQ-036 SHALL cover: load values, set busy on x4, assert rst together with wr_en -> all registers 0, busy_vec = 0 the next cycle.
